// File: rtl/median_filter_pipe_pkg.sv
// Shared definitions for the 3x3 median/min/max filter pipeline.
// Holds the per-window mode encodings and the fixed pipeline depth.
package median_filter_pipe_pkg;

   localparam int LAT = 3;

   typedef enum logic [1:0] {
      MODE_MEDIAN = 2'd0,
      MODE_MIN    = 2'd1,
      MODE_MAX    = 2'd2,
      MODE_PASS   = 2'd3
   } mode_e;

endpackage

// File: rtl/median_filter_pipe_sort3.sv
// Combinational three-input unsigned sorter.
// Outputs the inputs reordered as min/mid/max; ties pass the tied value through.
module sort3
   import median_filter_pipe_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic [DATA_W-1:0] min,
   output logic [DATA_W-1:0] mid,
   output logic [DATA_W-1:0] max
);

   logic [DATA_W-1:0] lo_ab;
   logic [DATA_W-1:0] hi_ab;
   logic [DATA_W-1:0] hi_abc;

   // Order a/b first; the larger of (lo_ab, c) then competes with hi_ab for max.
   always_comb begin
      lo_ab  = (a < b) ? a : b;
      hi_ab  = (a < b) ? b : a;
      min    = (lo_ab < c) ? lo_ab : c;
      hi_abc = (lo_ab < c) ? c : lo_ab;
      max    = (hi_ab < hi_abc) ? hi_abc : hi_ab;
      mid    = (hi_ab < hi_abc) ? hi_ab : hi_abc;
   end

endmodule

// File: rtl/median_filter_pipe.sv
// Three-stage 3x3 window filter: median, minimum, maximum or centre pass-through
// per window, with a single global stall (adv) driven by the output handshake.
module median_filter_pipe
   import median_filter_pipe_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LAT    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [9*DATA_W-1:0]   win_in,
   input  logic [1:0]            mode_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     pix_out,
   output logic [1:0]            mode_out
);

   if (LAT != median_filter_pipe_pkg::LAT) begin : g_lat_check
      $error("median_filter_pipe: LAT must be 3");
   end

   logic adv;

   logic [DATA_W-1:0] px        [9];
   logic [DATA_W-1:0] row_min_c [3];
   logic [DATA_W-1:0] row_mid_c [3];
   logic [DATA_W-1:0] row_max_c [3];

   logic [DATA_W-1:0] s1_min [3];
   logic [DATA_W-1:0] s1_mid [3];
   logic [DATA_W-1:0] s1_max [3];
   logic [DATA_W-1:0] s1_center;
   mode_e             s1_mode;
   logic              s1_valid;

   logic [DATA_W-1:0] gmin_c;
   logic [DATA_W-1:0] hi_c;
   logic [DATA_W-1:0] mid_c;
   logic [DATA_W-1:0] lo_c;
   logic [DATA_W-1:0] gmax_c;
   logic [DATA_W-1:0] unused_mins_mid;
   logic [DATA_W-1:0] unused_mids_min;
   logic [DATA_W-1:0] unused_mids_max;
   logic [DATA_W-1:0] unused_maxs_mid;

   logic [DATA_W-1:0] s2_hi;
   logic [DATA_W-1:0] s2_mid;
   logic [DATA_W-1:0] s2_lo;
   logic [DATA_W-1:0] s2_gmin;
   logic [DATA_W-1:0] s2_gmax;
   logic [DATA_W-1:0] s2_center;
   mode_e             s2_mode;
   logic              s2_valid;

   logic [DATA_W-1:0] med_c;
   logic [DATA_W-1:0] unused_cand_min;
   logic [DATA_W-1:0] unused_cand_max;
   logic [DATA_W-1:0] result_c;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < 9; k++) begin : g_px
      assign px[k] = win_in[k*DATA_W +: DATA_W];
   end

   for (genvar r = 0; r < 3; r++) begin : g_row
      sort3 #(.DATA_W(DATA_W)) u_row (
         .a   (px[3*r]),
         .b   (px[3*r+1]),
         .c   (px[3*r+2]),
         .min (row_min_c[r]),
         .mid (row_mid_c[r]),
         .max (row_max_c[r])
      );
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_min    <= row_min_c;
         s1_mid    <= row_mid_c;
         s1_max    <= row_max_c;
         s1_center <= px[4];
         s1_mode   <= mode_e'(mode_in);
      end
   end

   // Column of minima gives the global min and the max-of-minima candidate,
   // column of maxima gives the global max and the min-of-maxima candidate.
   sort3 #(.DATA_W(DATA_W)) u_mins (
      .a   (s1_min[0]),
      .b   (s1_min[1]),
      .c   (s1_min[2]),
      .min (gmin_c),
      .mid (unused_mins_mid),
      .max (hi_c)
   );

   sort3 #(.DATA_W(DATA_W)) u_mids (
      .a   (s1_mid[0]),
      .b   (s1_mid[1]),
      .c   (s1_mid[2]),
      .min (unused_mids_min),
      .mid (mid_c),
      .max (unused_mids_max)
   );

   sort3 #(.DATA_W(DATA_W)) u_maxs (
      .a   (s1_max[0]),
      .b   (s1_max[1]),
      .c   (s1_max[2]),
      .min (lo_c),
      .mid (unused_maxs_mid),
      .max (gmax_c)
   );

   always_ff @(posedge clk) begin
      if (adv) begin
         s2_hi     <= hi_c;
         s2_mid    <= mid_c;
         s2_lo     <= lo_c;
         s2_gmin   <= gmin_c;
         s2_gmax   <= gmax_c;
         s2_center <= s1_center;
         s2_mode   <= s1_mode;
      end
   end

   sort3 #(.DATA_W(DATA_W)) u_cand (
      .a   (s2_hi),
      .b   (s2_mid),
      .c   (s2_lo),
      .min (unused_cand_min),
      .mid (med_c),
      .max (unused_cand_max)
   );

   always_comb begin
      result_c = s2_center;
      case (s2_mode)
         MODE_MEDIAN: result_c = med_c;
         MODE_MIN:    result_c = s2_gmin;
         MODE_MAX:    result_c = s2_gmax;
         MODE_PASS:   result_c = s2_center;
         default:     result_c = s2_center;
      endcase
   end

   // Valid bits and the visible outputs are the only reset state; reset wins over adv.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         pix_out   <= '0;
         mode_out  <= 2'd0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         pix_out   <= result_c;
         mode_out  <= s2_mode;
      end
   end

endmodule

// File: tb/tb_median_filter_pipe.sv
// Directed and randomised bench for median_filter_pipe: vector table, latency,
// backpressure, reset flush, 12-bit instance and a sort-based scoreboard.
module tb_median_filter_pipe;
   import median_filter_pipe_pkg::*;

   localparam int DW = 8;
   typedef logic [9*DW-1:0] win_t;

   typedef struct {
      win_t       win;
      logic [1:0] mode;
      logic [7:0] exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   win_t          win_in;
   logic [1:0]    mode_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] pix_out;
   logic [1:0]    mode_out;

   logic          in_valid12;
   logic          in_ready12;
   logic [107:0]  win12;
   logic [1:0]    mode12;
   logic          out_valid12;
   logic          out_ready12;
   logic [11:0]   pix12;
   logic [1:0]    mode_out12;

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    drv_exp;
   logic [9:0]    exp_q [$];
   logic          prev_stall = 1'b0;
   logic [7:0]    prev_pix;
   logic [1:0]    prev_mode;

   always #5 clk = ~clk;

   median_filter_pipe #(.DATA_W(DW), .LAT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .win_in    (win_in),
      .mode_in   (mode_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pix_out   (pix_out),
      .mode_out  (mode_out)
   );

   median_filter_pipe #(.DATA_W(12), .LAT(3)) dut12 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid12),
      .in_ready  (in_ready12),
      .win_in    (win12),
      .mode_in   (mode12),
      .out_valid (out_valid12),
      .out_ready (out_ready12),
      .pix_out   (pix12),
      .mode_out  (mode_out12)
   );

   function automatic win_t mk(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
      int p [9];
      win_t w;
      p = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
      for (int k = 0; k < 9; k++) w[k*DW +: DW] = p[k][7:0];
      return w;
   endfunction

   // Reference: full sort of the nine pixels, then pick the order statistic.
   function automatic logic [7:0] ref_calc(input win_t w, input logic [1:0] m);
      logic [7:0] s [9];
      logic [7:0] t;
      for (int k = 0; k < 9; k++) s[k] = w[k*DW +: DW];
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8 - i; j++)
            if (s[j] > s[j+1]) begin
               t = s[j]; s[j] = s[j+1]; s[j+1] = t;
            end
      case (m)
         2'd0:    return s[4];
         2'd1:    return s[0];
         2'd2:    return s[8];
         default: return w[4*DW +: DW];
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input win_t w, input logic [1:0] m, input logic [7:0] e);
      in_valid = v;
      win_in   = w;
      mode_in  = m;
      drv_exp  = e;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic latencyCheck(input string name, input win_t w, input logic [1:0] m, input logic [7:0] e);
      out_ready = 1'b1;
      applyStimulus(1'b1, w, m, e);
      step();
      applyStimulus(1'b0, '0, 2'd0, 8'd0);
      checkOutput({name, "_c1_valid"}, out_valid, 1'b0);
      step();
      checkOutput({name, "_c2_valid"}, out_valid, 1'b0);
      step();
      checkOutput({name, "_c3_valid"}, out_valid, 1'b1);
      checkOutput({name, "_c3_pix"}, pix_out, e);
      step();
   endtask

   task automatic waitDrain(input string name);
      int n;
      out_ready = 1'b1;
      applyStimulus(1'b0, '0, 2'd0, 8'd0);
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         step();
         n++;
      end
      checkOutput({name, "_drain_left"}, exp_q.size(), 0);
   endtask

   // Scoreboard: outputs are matched against accepted windows in order.
   always @(negedge clk) begin
      logic [9:0] e;
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         checkOutput("in_ready_rule", in_ready, (!out_valid) || out_ready);
         if (prev_stall) begin
            checkOutput("stall_valid", out_valid, 1'b1);
            checkOutput("stall_pix", pix_out, prev_pix);
            checkOutput("stall_mode", mode_out, prev_mode);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output actual=%0h required=none at %0t", pix_out, $time);
            end else begin
               e = exp_q.pop_front();
               checkOutput("result_pix", pix_out, e[7:0]);
               checkOutput("result_mode", mode_out, e[9:8]);
            end
         end
         if (in_valid && in_ready) exp_q.push_back({mode_in, drv_exp});
         prev_stall = out_valid && !out_ready;
         prev_pix   = pix_out;
         prev_mode  = mode_out;
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs [15];
      win_t ramp;
      win_t w;
      logic [1:0] m;
      int sent;
      int accepted;
      int cyc;
      logic pending;

      ramp = mk(9, 1, 8, 2, 7, 3, 6, 4, 5);
      w    = mk(200, 17, 255, 0, 99, 3, 64, 128, 50);
      vecs[0]  = '{ramp, 2'd0, 8'd5};
      vecs[1]  = '{w, 2'd1, 8'd0};
      vecs[2]  = '{w, 2'd2, 8'd255};
      vecs[3]  = '{w, 2'd3, 8'd99};
      vecs[4]  = '{w, 2'd0, 8'd64};
      vecs[5]  = '{mk(255, 255, 255, 255, 255, 255, 255, 255, 255), 2'd0, 8'd255};
      vecs[6]  = '{mk(0, 0, 0, 0, 255, 255, 255, 255, 255), 2'd0, 8'd255};
      vecs[7]  = '{mk(255, 255, 255, 255, 0, 0, 0, 0, 0), 2'd0, 8'd0};
      vecs[8]  = '{ramp, 2'd1, 8'd1};
      vecs[9]  = '{ramp, 2'd2, 8'd9};
      vecs[10] = '{ramp, 2'd3, 8'd7};
      vecs[11] = '{mk(5, 5, 5, 1, 1, 9, 9, 9, 5), 2'd0, 8'd5};
      vecs[12] = '{mk(90, 80, 70, 60, 50, 40, 30, 20, 10), 2'd0, 8'd50};
      vecs[13] = '{mk(3, 200, 3, 200, 3, 200, 200, 3, 200), 2'd0, 8'd200};
      vecs[14] = '{mk(1, 100, 101, 2, 3, 102, 50, 51, 52), 2'd0, 8'd51};

      rst         = 1'b1;
      out_ready   = 1'b1;
      applyStimulus(1'b0, '0, 2'd0, 8'd0);
      in_valid12  = 1'b0;
      win12       = '0;
      mode12      = 2'd0;
      out_ready12 = 1'b1;
      step();
      step();
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_pix", pix_out, 8'd0);
      checkOutput("reset_mode", mode_out, 2'd0);
      rst       = 1'b0;
      out_ready = 1'b0;
      step();
      checkOutput("post_reset_in_ready", in_ready, 1'b1);

      latencyCheck("ramp_latency", ramp, 2'd0, 8'd5);
      waitDrain("ramp");

      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, vecs[i].win, vecs[i].mode, vecs[i].exp);
         step();
      end
      waitDrain("table");

      // Backpressure: out_ready follows 1,0,0 while six windows stream in.
      sent = 0;
      cyc  = 0;
      while ((sent < 6 || exp_q.size() != 0 || out_valid) && cyc < 80) begin
         out_ready = (cyc % 3 == 0);
         w = mk(10 * sent, 7, 250 - sent, 33, 5 * sent + 1, 90, 2, 120 + sent, 60);
         m = 2'(sent % 4);
         applyStimulus(sent < 6, w, m, ref_calc(w, m));
         #1;
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      checkOutput("bp_sent", sent, 6);
      waitDrain("backpressure");

      // Reset with two windows in flight: neither may emerge.
      out_ready = 1'b1;
      applyStimulus(1'b1, ramp, 2'd0, 8'd5);
      step();
      applyStimulus(1'b1, vecs[1].win, 2'd1, 8'd0);
      step();
      applyStimulus(1'b0, '0, 2'd0, 8'd0);
      rst = 1'b1;
      step();
      checkOutput("rst_mid_valid", out_valid, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("rst_flush_valid", out_valid, 1'b0);
      end
      latencyCheck("rst_fresh", vecs[14].win, 2'd0, 8'd51);
      waitDrain("reset");

      // 12-bit instance: saturated window and a single low pixel under min.
      in_valid12 = 1'b1;
      win12      = '1;
      mode12     = 2'd0;
      step();
      win12[5*12 +: 12] = 12'h800;
      mode12     = 2'd1;
      step();
      in_valid12 = 1'b0;
      checkOutput("w12_in_ready", in_ready12, 1'b1);
      step();
      checkOutput("w12_a_valid", out_valid12, 1'b1);
      checkOutput("w12_a_pix", pix12, 12'hFFF);
      checkOutput("w12_a_mode", mode_out12, 2'd0);
      step();
      checkOutput("w12_b_valid", out_valid12, 1'b1);
      checkOutput("w12_b_pix", pix12, 12'h800);
      checkOutput("w12_b_mode", mode_out12, 2'd1);
      step();

      // Random traffic with held windows under backpressure and clustered pixel values.
      accepted = 0;
      cyc      = 0;
      pending  = 1'b0;
      while (accepted < 10000 && cyc < 40000) begin
         if (!pending) begin
            pending = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < 9; k++)
               w[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3) * 85)
                                                           : 8'($urandom);
            m = 2'($urandom_range(0, 3));
         end
         applyStimulus(pending, w, m, ref_calc(w, m));
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (pending && in_ready) begin
            accepted++;
            pending = 1'b0;
         end
         step();
         cyc++;
      end
      checkOutput("random_accepted", accepted, 10000);
      waitDrain("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/median_filter_pipe.md
MEDIAN_FILTER_PIPE -- requirements
Module: median_filter_pipe

Interface
REQ-001 Parameter: DATA_W, default 8, sets the bit width of each pixel.
REQ-002 Parameter: LAT, default 3, sets the pipeline depth; it is fixed at 3, and any other value SHALL fail elaboration.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  a window is presented on win_in.
REQ-006 in_ready  output  1  block accepts a window this cycle.
REQ-007 win_in  input  9*DATA_W  3x3 window, packed row-major; pixel k occupies bits [k*DATA_W +: DATA_W], k=0..8.
REQ-008 mode_in  input  2  per-window operation: 0 median, 1 minimum, 2 maximum, 3 centre pass-through (pixel 4).
REQ-009 out_valid  output  1  pix_out holds a result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 pix_out  output  DATA_W  filtered pixel.
REQ-012 mode_out  output  2  mode that produced pix_out.

Function
REQ-013 Transfer in: a window SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-014 Transfer out: a result SHALL be delivered only on a cycle with out_valid=1 and out_ready=1.
REQ-015 Global enable: adv = ~out_valid | out_ready; in_ready SHALL equal adv combinationally; all three stages SHALL shift only when adv=1.
REQ-016 When adv=1, each stage valid bit SHALL load the previous stage valid bit; stage-0 valid SHALL load in_valid; empty stages SHALL propagate as bubbles.
REQ-017 When adv=0, all stage data, valid bits and modes SHALL hold; pix_out and mode_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 Latency: a window accepted in cycle N with no stall SHALL produce out_valid=1 in cycle N+3; each stall cycle SHALL add one cycle.
REQ-019 Throughput: one window per cycle when out_ready is held at 1.
REQ-020 Stage 1 SHALL sort each row ascending into (min, mid, max) and register pixel 4 and the mode.
REQ-021 Stage 2 SHALL register five values:
- max of the row minima;
- mid of the row mids;
- min of the row maxima;
- min of the row minima;
- max of the row maxima.
REQ-022 Stage 3 SHALL select the output by the carried mode:
- 0: mid of the three stage-2 candidates (max of minima, mid of mids, min of maxima);
- 1: global minimum;
- 2: global maximum;
- 3: the carried centre pixel.
REQ-023 Comparisons SHALL be unsigned; no arithmetic widening; ties SHALL produce the tied value, and the result SHALL equal the true order statistic for every input.
REQ-024 The mode SHALL be sampled per window at acceptance; a mode change mid-stream SHALL affect only later windows.
REQ-025 When in_valid=1 and in_ready=0, the upstream holds its data; the block SHALL NOT capture it.

Reset
REQ-026 With rst=1 at a clock edge, all stage valid bits, out_valid, pix_out and mode_out SHALL clear to 0; rst has priority over adv.
REQ-027 Reset mid-operation SHALL discard all in-flight windows; nothing is emitted for them.
REQ-028 In the cycle after reset is released, in_ready SHALL be 1.
REQ-029 Datapath registers other than the outputs need no reset.

Structure
REQ-030 A shared package SHALL hold:
- mode encodings MODE_MEDIAN=0, MODE_MIN=1, MODE_MAX=2, MODE_PASS=3;
- the LAT constant.
REQ-031 A combinational sub-module, sort3 (parametrised by DATA_W, outputs min/mid/max), SHALL be instantiated for the row sorts and the candidate sorts; registers SHALL be in median_filter_pipe.

Verification
REQ-032 Median ramp: mode=0, window 9,1,8,2,7,3,6,4,5 with out_ready=1 -> pix_out=5 exactly 3 cycles later.
REQ-033 Modes: window 200,17,255,0,99,3,64,128,50 sent with modes 1,2,3,0 back-to-back -> outputs 0,255,99,64 on four consecutive cycles, with mode_out 1,2,3,0.
REQ-034 Ties/extremes, mode=0:
- all pixels 0xFF -> 0xFF;
- pixels 0,0,0,0,255,255,255,255,255 -> 255;
- DATA_W=12, all pixels 0xFFF -> 0xFFF.
REQ-035 Backpressure: stream 6 windows while out_ready toggles 1,0,0,1,... -> no loss or duplication, in-order results, pix_out stable while stalled, in_ready=0 exactly when out_valid=1 and out_ready=0.
REQ-036 Reset mid-stream: assert rst one cycle after 2 windows are in flight -> out_valid=0 the next cycle, no stale result emitted, and a fresh window afterwards returns after 3 cycles.
REQ-037 Random: 10k random windows, random modes and random valid/ready -> each result matches a sort-based reference model.
